alarm_ctrl: RTL
===============

Name: alarm_ctrl

Overview:
- Alarm controller downstream of counter_24hr on DE0_CV.
- Consumes the BCD time digits (HH:MM) produced by counter_24hr and holds a user-programmable alarm time.
- Raises a ringing flag and a toggling buzzer drive when the time reaches the alarm, with snooze, stop and auto-timeout.
- Alarm digits are output for the HEX display path.

Parameters:
RING_MINUTES, 5, minute ticks spent ringing before auto-stop (1..15)
SNOOZE_MINUTES, 9, minute ticks spent snoozed before re-ringing (1..15)
BUZZ_DIV, 4, clk cycles per buzzer half-period (>=1)
CHIME_CYCLES, 8, chime pulse length in clk cycles (only used with ALARM_CHIME_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous reset, active-high
hours_tens  input  4  BCD 0..2 from counter_24hr
hours_ones  input  4  BCD 0..9 (0..3 when tens=2)
minutes_tens  input  4  BCD 0..5
minutes_ones  input  4  BCD 0..9
alarm_on  input  1  level; 0 disables and cancels the alarm
set_mode  input  1  level; 1 = editing alarm time
set_hour  input  1  one-cycle pulse; increment alarm hour
set_min  input  1  one-cycle pulse; increment alarm minute
snooze  input  1  one-cycle pulse
stop  input  1  one-cycle pulse
alarm_hours_tens  output  4  BCD alarm hour tens
alarm_hours_ones  output  4  BCD alarm hour ones
alarm_minutes_tens  output  4  BCD alarm minute tens
alarm_minutes_ones  output  4  BCD alarm minute ones
ringing  output  1  high in RINGING state
snoozed  output  1  high in SNOOZED state
buzzer  output  1  square wave while ringing, else 0
chime  output  1  hourly chime pulse (0 without macro)

Behaviour:
- Reset values:
  - alarm time = 06:00 (digits 0,6,0,0).
  - state = IDLE; ringing = snoozed = buzzer = chime = 0.
  - Ring/snooze counters = 0.
  - match_d = 1, so no ring fires on the first cycle after reset.
  - min_prev = 0.
- All outputs are registered.
- minute_tick = (minutes_ones != min_prev); min_prev is registered every cycle.
- match = alarm_on & all four time digits equal the alarm digits.
- trigger = match & ~match_d. This fires once per match entry, so stop within the matching minute does not retrigger.
- Alarm edit:
  - Only when set_mode=1.
  - set_hour increments the hour 00..23 and wraps 23->00 (tens/ones kept BCD, 09->10, 19->20).
  - set_min increments the minute 00..59 and wraps 59->00 without changing the hour.
  - Both pulses in the same cycle: both increments apply.
  - Pulses while set_mode=0 are ignored.
- FSM, states IDLE, RINGING, SNOOZED. Per-cycle priority (highest first):
  1. ~alarm_on or set_mode -> IDLE (from any state; counters cleared).
  2. stop -> IDLE (from RINGING or SNOOZED).
  3. snooze in RINGING -> SNOOZED; snooze counter loads SNOOZE_MINUTES.
  4. IDLE & trigger -> RINGING; ring counter cleared.
  5. RINGING & minute_tick: ring counter +1. When the counter reaches RING_MINUTES -> IDLE.
  6. SNOOZED & minute_tick: snooze counter -1. On transition 1->0 -> RINGING; ring counter cleared.
- snooze in IDLE or SNOOZED is ignored; stop in IDLE is ignored.
- Latency: ringing rises 1 clk after the cycle in which the time digits first equal the alarm.
- Buzzer:
  - Toggles every BUZZ_DIV clk while in RINGING; its divider starts at 0 on RINGING entry.
  - Forced 0 in the same cycle ringing drops.

Optional Feature:
ALARM_CHIME_EN
- Defined:
  - When minute_tick occurs and the new time is minutes_tens=0, minutes_ones=0, chime goes high for CHIME_CYCLES clk.
  - Chime is suppressed while RINGING.
  - Chime is independent of alarm_on.
  - A new hour edge during an active pulse restarts the pulse.
- Not defined: chime is tied to 0 and no chime logic is synthesized.

Test Plan:
- Reset -> alarm digits 0,6,0,0; ringing=0, buzzer=0, snoozed=0.
- set_mode=1, 18 set_hour pulses, then 59 set_min pulses -> alarm 00:59; 1 more set_min -> 00:00, hour unchanged.
- Alarm 00:02, alarm_on=1, counter runs from 00:00 -> ringing=1 one clk after time reads 00:02; buzzer period 2*BUZZ_DIV clk; ringing auto-drops after the 5th subsequent minute tick (time 00:07).
- Ringing at 00:02, snooze pulse -> snoozed=1, ringing=0; at time 00:11 ringing=1 again; stop pulse -> IDLE, no retrigger while time stays 00:11.
- Ringing, alarm_on dropped, or set_mode raised in the same cycle as snooze -> IDLE (priority 1 wins), buzzer=0 next clk.
- ALARM_CHIME_EN defined, time 00:59->01:00 -> chime high exactly 8 clk; macro undefined -> chime stays 0.

Source files
------------

// File: rtl/alarm_ctrl.sv
// Alarm controller fed by counter_24hr BCD time: programmable alarm, ring/snooze/stop, buzzer drive.
// Optional hourly chime is built only when ALARM_CHIME_EN is defined; otherwise chime is tied low.
module alarm_ctrl #(
  parameter int RING_MINUTES   = 5,
  parameter int SNOOZE_MINUTES = 9,
  parameter int BUZZ_DIV       = 4,
  parameter int CHIME_CYCLES   = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] hours_tens,
  input  logic [3:0] hours_ones,
  input  logic [3:0] minutes_tens,
  input  logic [3:0] minutes_ones,
  input  logic       alarm_on,
  input  logic       set_mode,
  input  logic       set_hour,
  input  logic       set_min,
  input  logic       snooze,
  input  logic       stop,
  output logic [3:0] alarm_hours_tens,
  output logic [3:0] alarm_hours_ones,
  output logic [3:0] alarm_minutes_tens,
  output logic [3:0] alarm_minutes_ones,
  output logic       ringing,
  output logic       snoozed,
  output logic       buzzer,
  output logic       chime
);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_e;

  localparam int              BW        = (BUZZ_DIV > 1) ? $clog2(BUZZ_DIV) : 1;
  localparam logic [3:0]      RING_N    = 4'(RING_MINUTES);
  localparam logic [3:0]      SNOOZE_N  = 4'(SNOOZE_MINUTES);
  localparam logic [BW-1:0]   BUZZ_LAST = BW'(BUZZ_DIV - 1);

  if (RING_MINUTES < 1 || RING_MINUTES > 15 || SNOOZE_MINUTES < 1 || SNOOZE_MINUTES > 15 ||
      BUZZ_DIV < 1 || CHIME_CYCLES < 1) begin : g_bad_params
    $error("alarm_ctrl: parameter out of range");
  end

  state_e        state_q, state_d;
  logic [3:0]    ah_t_q, ah_t_d, ah_o_q, ah_o_d, am_t_q, am_t_d, am_o_q, am_o_d;
  logic [3:0]    ring_cnt_q, ring_cnt_d, snz_cnt_q, snz_cnt_d;
  logic [BW-1:0] buzz_cnt_q, buzz_cnt_d;
  logic          buzzer_q, buzzer_d, ringing_q, snoozed_q;
  logic          match_prev_q;
  logic [3:0]    min_prev_q;
  logic          match, trigger, minute_tick;

  assign match = alarm_on &&
                 ({hours_tens, hours_ones, minutes_tens, minutes_ones} == {ah_t_q, ah_o_q, am_t_q, am_o_q});
  assign trigger     = match && !match_prev_q;
  assign minute_tick = (minutes_ones != min_prev_q);

  // Alarm time edit: BCD increments with 23->00 and 59->00 wraps.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    ah_t_d = ah_t_q;
    ah_o_d = ah_o_q;
    am_t_d = am_t_q;
    am_o_d = am_o_q;
    if (set_mode) begin
      if (set_hour) begin
        if (ah_t_q == 4'd2 && ah_o_q == 4'd3) begin
          ah_t_d = 4'd0;
          ah_o_d = 4'd0;
        end else if (ah_o_q == 4'd9) begin
          ah_t_d = ah_t_q + 4'd1;
          ah_o_d = 4'd0;
        end else begin
          ah_o_d = ah_o_q + 4'd1;
        end
      end
      if (set_min) begin
        if (am_o_q == 4'd9) begin
          am_o_d = 4'd0;
          am_t_d = (am_t_q == 4'd5) ? 4'd0 : am_t_q + 4'd1;
        end else begin
          am_o_d = am_o_q + 4'd1;
        end
      end
    end
  end

  // State transitions in priority order: cancel, stop, snooze, then per-state behaviour.
  always_comb begin
    state_d    = state_q;
    ring_cnt_d = ring_cnt_q;
    snz_cnt_d  = snz_cnt_q;
    if (!alarm_on || set_mode || (stop && state_q != IDLE)) begin
      state_d    = IDLE;
      ring_cnt_d = 4'd0;
      snz_cnt_d  = 4'd0;
    end else if (snooze && state_q == RINGING) begin
      state_d    = SNOOZED;
      ring_cnt_d = 4'd0;
      snz_cnt_d  = SNOOZE_N;
    end else begin
      case (state_q)
        IDLE: begin
          if (trigger) begin
            state_d    = RINGING;
            ring_cnt_d = 4'd0;
          end
        end
        RINGING: begin
          if (minute_tick) begin
            if (ring_cnt_q + 4'd1 == RING_N) begin
              state_d    = IDLE;
              ring_cnt_d = 4'd0;
            end else begin
              ring_cnt_d = ring_cnt_q + 4'd1;
            end
          end
        end
        SNOOZED: begin
          if (minute_tick) begin
            snz_cnt_d = snz_cnt_q - 4'd1;
            if (snz_cnt_q == 4'd1) begin
              state_d    = RINGING;
              ring_cnt_d = 4'd0;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Divider restarts on every RINGING entry; buzzer drops with ringing in the same cycle.
  always_comb begin
    buzz_cnt_d = '0;
    buzzer_d   = 1'b0;
    if (state_d == RINGING && state_q == RINGING) begin
      if (buzz_cnt_q == BUZZ_LAST) begin
        buzzer_d = ~buzzer_q;
      end else begin
        buzz_cnt_d = buzz_cnt_q + BW'(1);
        buzzer_d   = buzzer_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      ah_t_q       <= 4'd0;
      ah_o_q       <= 4'd6;
      am_t_q       <= 4'd0;
      am_o_q       <= 4'd0;
      ring_cnt_q   <= 4'd0;
      snz_cnt_q    <= 4'd0;
      buzz_cnt_q   <= '0;
      buzzer_q     <= 1'b0;
      ringing_q    <= 1'b0;
      snoozed_q    <= 1'b0;
      match_prev_q <= 1'b1;
      min_prev_q   <= 4'd0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q      <= state_d;
      ah_t_q       <= ah_t_d;
      ah_o_q       <= ah_o_d;
      am_t_q       <= am_t_d;
      am_o_q       <= am_o_d;
      ring_cnt_q   <= ring_cnt_d;
      snz_cnt_q    <= snz_cnt_d;
      buzz_cnt_q   <= buzz_cnt_d;
      buzzer_q     <= buzzer_d;
      ringing_q    <= (state_d == RINGING);
      snoozed_q    <= (state_d == SNOOZED);
      match_prev_q <= match;
      min_prev_q   <= minutes_ones;
    end
  end

  assign alarm_hours_tens   = ah_t_q;
  assign alarm_hours_ones   = ah_o_q;
  assign alarm_minutes_tens = am_t_q;
  assign alarm_minutes_ones = am_o_q;
  assign ringing            = ringing_q;
  assign snoozed            = snoozed_q;
  assign buzzer             = buzzer_q;

`ifdef ALARM_CHIME_EN
  localparam int            CW         = $clog2(CHIME_CYCLES + 1);
  localparam logic [CW-1:0] CHIME_LAST = CW'(CHIME_CYCLES - 1);

  logic [CW-1:0] chime_cnt_q, chime_cnt_d;
  logic          chime_q, chime_d, hour_edge;

  assign hour_edge = minute_tick && minutes_tens == 4'd0 && minutes_ones == 4'd0;

  // A fresh hour edge reloads the count, so overlapping edges restart the pulse.
  always_comb begin
    chime_cnt_d = '0;
    chime_d     = 1'b0;
    if (state_d != RINGING) begin
      if (hour_edge) begin
        chime_cnt_d = CHIME_LAST;
        chime_d     = 1'b1;
      end else if (chime_q && chime_cnt_q != '0) begin
        chime_cnt_d = chime_cnt_q - CW'(1);
        chime_d     = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chime_cnt_q <= '0;
      chime_q     <= 1'b0;
    end else begin
      chime_cnt_q <= chime_cnt_d;
      chime_q     <= chime_d;
    end
  end

  assign chime = chime_q;
`else
  assign chime = 1'b0;
`endif

endmodule
